// File: rtl/dec38_case.sv
// dec38_case: registered 8-to-3 one-hot encoder.
// Produces the binary index of the asserted bit of q one clock after sampling.
// It also reports whether q was a legal one-hot code (valid) or had two or
// more bits set (err). Multi-hot inputs resolve to the highest set bit.
module dec38_case (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] q,
  output logic [2:0] d,
  output logic       valid,
  output logic       err
);

  // Index of the highest set bit. An all-zero word maps to 0.
  function automatic logic [2:0] msb_index(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Number of set bits in the select word.
  function automatic logic [3:0] ones_count(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

  logic [2:0] idx_p0;
  logic [3:0] ones_p0;
  logic       onehot_p0;
  logic       multi_p0;

  // Stage p0: combinational encode and bit count of the raw input.
  always_comb begin
    idx_p0 = 3'd0;
    case (q)
      8'b0000_0001: idx_p0 = 3'd0;
      8'b0000_0010: idx_p0 = 3'd1;
      8'b0000_0100: idx_p0 = 3'd2;
      8'b0000_1000: idx_p0 = 3'd3;
      8'b0001_0000: idx_p0 = 3'd4;
      8'b0010_0000: idx_p0 = 3'd5;
      8'b0100_0000: idx_p0 = 3'd6;
      8'b1000_0000: idx_p0 = 3'd7;
      // Zero and multi-hot words: MSB priority (zero gives 0).
      default:      idx_p0 = msb_index(q);
    endcase
    ones_p0   = ones_count(q);
    onehot_p0 = (ones_p0 == 4'd1);
    multi_p0  = (ones_p0 >= 4'd2);
  end

  // Stage p1: register index and status; reset overrides the sampled word.
  always_ff @(posedge clk) begin
    if (rst) begin
      d     <= 3'd0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      d     <= idx_p0;
      valid <= onehot_p0;
      err   <= multi_p0;
    end
  end

endmodule

// File: tb/tb_dec38_case.sv
// tb_dec38_case: scoreboard bench for the registered one-hot encoder.
module tb_dec38_case;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] q;
  logic [2:0] d;
  logic       valid;
  logic       err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] d;
    logic       valid;
    logic       err;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  dec38_case dut (
    .clk   (clk),
    .rst   (rst),
    .q     (q),
    .d     (d),
    .valid (valid),
    .err   (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: popcount for status, descending scan for the index.
  function automatic exp_t model(input logic [7:0] v, input logic r);
    exp_t e;
    int   n;
    logic found;
    e = '0;
    if (!r) begin
      n = $countones(v);
      found = 1'b0;
      for (int i = 7; i >= 0; i--) begin
        if (v[i] && !found) begin
          e.d = 3'(i);
          found = 1'b1;
        end
      end
      e.valid = (n == 1);
      e.err   = (n >= 2);
    end
    return e;
  endfunction

  // Drive one input word, push its expected result, then compare after the edge.
  task automatic step(input logic [7:0] v, input logic r);
    exp_t e;
    q   = v;
    rst = r;
    sb.push_back(model(v, r));
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("d",     32'(d),     32'(e.d));
      check("valid", 32'(valid), 32'(e.valid));
      check("err",   32'(err),   32'(e.err));
    end
  endtask

  initial begin
    logic [7:0] oh;
    logic [7:0] rv;

    // Reset held for two cycles with all bits set on q.
    step(8'hFF, 1'b1);
    step(8'hFF, 1'b1);
    check("rst_d", 32'(d), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // Zero input after reset.
    for (int i = 0; i < 10; i++) begin
      step(8'h00, 1'b0);
      check("zero_valid", 32'(valid), 32'd0);
    end
    // One-hot bit 0 is distinguishable from zero by valid.
    step(8'h01, 1'b0);
    check("h01_valid", 32'(valid), 32'd1);
    check("h01_d", 32'(d), 32'd0);

    // One-hot sweep.
    for (int i = 0; i < 8; i++) begin
      oh = 8'h01 << i;
      step(oh, 1'b0);
      check("sweep_d", 32'(d), 32'(i));
      check("sweep_valid", 32'(valid), 32'd1);
      check("sweep_err", 32'(err), 32'd0);
    end

    // Multi-hot words resolve to the highest set bit.
    step(8'h81, 1'b0);
    check("h81_d", 32'(d), 32'd7);
    check("h81_err", 32'(err), 32'd1);
    step(8'h0C, 1'b0);
    check("h0c_d", 32'(d), 32'd3);
    check("h0c_err", 32'(err), 32'd1);
    step(8'hFF, 1'b0);
    check("hff_d", 32'(d), 32'd7);
    check("hff_valid", 32'(valid), 32'd0);

    // Reset mid-stream discards the pending sample.
    step(8'h20, 1'b0);
    check("mid_d0", 32'(d), 32'd5);
    step(8'h40, 1'b1);
    check("mid_d1", 32'(d), 32'd0);
    check("mid_v1", 32'(valid), 32'd0);
    step(8'h40, 1'b0);
    check("mid_d2", 32'(d), 32'd6);
    check("mid_v2", 32'(valid), 32'd1);

    // Hold then switch.
    for (int i = 0; i < 5; i++) begin
      step(8'h10, 1'b0);
      check("hold_d", 32'(d), 32'd4);
    end
    step(8'h02, 1'b0);
    check("switch_d", 32'(d), 32'd1);

    // Random words, biased toward one-hot and sparse codes.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0:       rv = 8'h01 << $urandom_range(0, 7);
        1:       rv = (8'h01 << $urandom_range(0, 7)) | (8'h01 << $urandom_range(0, 7));
        default: rv = 8'($urandom_range(0, 255));
      endcase
      step(rv, 1'b0);
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
